data_mem_slave: RTL and testbench
=================================

Name: data_mem_slave

Overview:
- Synthesizable multi-channel data memory that consumes the GPU's data-memory interface (per-channel read/write valid-ready).
- Replaces the behavioural memory model on the bench and in FPGA builds.
- Adds configurable access latency, fixed-priority write arbitration onto a single write port, and a backdoor load port for preloading matrices and kernels' data.

Parameters:
- ADDR_BITS, 8, address width; the array holds 2**ADDR_BITS words.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 4, number of independent request channels. Matches the GPU data-memory channel count.
- LATENCY, 1, cycles from request acceptance to ready pulse (legal range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low: 0 resets all state immediately; deassertion is synchronised externally
- read_valid  in  [NUM_CHANNELS]  per-channel read request
- read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address
- read_ready  out  [NUM_CHANNELS]  one-cycle read completion pulse
- read_data  out  [DATA_BITS] x NUM_CHANNELS  read data, valid while read_ready=1 and held until the next read completes
- write_valid  in  [NUM_CHANNELS]  per-channel write request
- write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address
- write_data  in  [DATA_BITS] x NUM_CHANNELS  write data
- write_ready  out  [NUM_CHANNELS]  one-cycle write completion pulse
- load_en  in  1  backdoor write strobe
- load_address  in  ADDR_BITS  backdoor address
- load_data  in  DATA_BITS  backdoor data
- busy  out  1  OR of all channels not in IDLE

Behaviour:
- Reset:
  - All read_ready/write_ready/busy = 0, read_data = 0, every channel FSM in IDLE, latency counters 0.
  - Array contents are NOT cleared.
- Per-channel FSM: IDLE -> WAIT -> RESP -> RELEASE -> IDLE.
- IDLE:
  - On a sampled edge with write_valid=1, latch op=WRITE, address and data.
  - Otherwise, if read_valid=1, latch op=READ and address.
  - In both cases load counter=LATENCY-1 and go to WAIT.
  - If both valids are high, the write is served first; the read is accepted in a later IDLE.
- WAIT:
  - If counter>0, decrement.
  - At counter=0, a READ samples the array and the channel goes to RESP. read_data registers the array word and read_ready=1 in the next cycle.
  - At counter=0, a WRITE requests the write port. If granted, the array is written at that edge and the channel goes to RESP; if not granted, it stays in WAIT with counter=0.
  - LATENCY=1 means ready is high in the cycle after valid is first sampled high.
- RESP: the channel's ready is high for exactly this one cycle, then the channel goes to RELEASE.
- RELEASE: the channel stays until the corresponding valid is sampled low, then goes to IDLE. A held-high valid never produces a second ready.
- Write port:
  - One array write per cycle.
  - Fixed priority, lowest channel index wins among channels in WAIT with counter=0 and op=WRITE.
  - load_en has priority over all channels. While load_en=1, no channel write is granted.
- Reads:
  - Unlimited parallel reads per cycle.
  - Read and write to the same address on the same edge: the read returns the old word (read-before-write).
- Latched request fields are frozen after IDLE. Address and data changes during WAIT are ignored.
- Addresses wrap naturally at 2**ADDR_BITS. No out-of-range condition exists.
- Reset asserted mid-transaction:
  - The transaction is aborted and ready is never pulsed.
  - An array write already performed stays; one not yet performed does not occur.
- busy=1 whenever any channel is in WAIT, RESP, or RELEASE.

Test Plan:
- Preload addr 0..7 = {1,2,3,4,1,2,3,4} via load_en. Ch0 reads addr 2 with LATENCY=1 -> read_ready[0] high one cycle after valid sampled, read_data[0]=3.
- LATENCY=3, ch1 reads addr 5 -> read_ready[1] asserts exactly 3 cycles after acceptance, data 2, single-cycle pulse.
- All 4 channels write addr 8..11 = {7,10,15,22} in the same cycle -> write_ready pulses on ch0, ch1, ch2, ch3 on 4 consecutive cycles. A subsequent read returns 7,10,15,22.
- Ch0 writes addr 4 = 9 while ch1 reads addr 4 on the same completion edge -> ch1 gets 1; a later read gets 9.
- Ch2 holds read_valid high for 5 cycles after its ready -> exactly one read_ready[2] pulse. Dropping valid returns the channel to IDLE and busy=0.
- Assert reset (0) while ch3 is in WAIT on a write of addr 20 -> all outputs 0 immediately, no ready pulse, and addr 20 keeps its preloaded value.

Source files
------------

// File: rtl/data_mem_slave.sv
// Multi-channel data memory: one request FSM per channel with configurable latency,
// a single fixed-priority write port where the backdoor load wins, and unlimited parallel reads.
module data_mem_slave #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]                read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]                write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]                write_ready,
  input  logic                                   load_en,
  input  logic [ADDR_BITS-1:0]                   load_address,
  input  logic [DATA_BITS-1:0]                   load_data,
  output logic                                   busy
);
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_e;

  logic [DATA_BITS-1:0]                   mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0]                wr_req, grant, ch_busy;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_wdata;
  logic                                   wr_en;
  logic [ADDR_BITS-1:0]                   wr_addr;
  logic [DATA_BITS-1:0]                   wr_data;

  // Load owns the port outright; otherwise the lowest requesting channel wins.
  always_comb begin
    grant   = '0;
    wr_en   = load_en;
    wr_addr = load_address;
    wr_data = load_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_req[c] && !wr_en) begin
        grant[c] = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = ch_addr[c];
        wr_data  = ch_wdata[c];
      end
    end
  end

  // Array contents survive reset; only channel state is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_e               state_q;
    logic                 op_wr_q, rrdy_q, wrdy_q;
    logic [3:0]           cnt_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q, rdata_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_IDLE;
        op_wr_q <= 1'b0;
        rrdy_q  <= 1'b0;
        wrdy_q  <= 1'b0;
        cnt_q   <= 4'd0;
        addr_q  <= '0;
        wdata_q <= '0;
        rdata_q <= '0;
      end else begin
        rrdy_q <= 1'b0;
        wrdy_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (write_valid[c]) begin
              op_wr_q <= 1'b1;
              addr_q  <= write_address[c];
              wdata_q <= write_data[c];
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end else if (read_valid[c]) begin
              op_wr_q <= 1'b0;
              addr_q  <= read_address[c];
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (!op_wr_q) begin
              // Sampled before any same-edge array write lands: read-before-write.
              rdata_q <= mem_q[addr_q];
              rrdy_q  <= 1'b1;
              state_q <= S_RESP;
            end else if (grant[c]) begin
              wrdy_q  <= 1'b1;
              state_q <= S_RESP;
            end
          end
          S_RESP: state_q <= S_RELEASE;
          S_RELEASE: begin
            if (!(op_wr_q ? write_valid[c] : read_valid[c])) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign wr_req[c]      = (state_q == S_WAIT) && (cnt_q == 4'd0) && op_wr_q;
    assign ch_addr[c]     = addr_q;
    assign ch_wdata[c]    = wdata_q;
    assign ch_busy[c]     = (state_q != S_IDLE);
    assign read_ready[c]  = rrdy_q;
    assign write_ready[c] = wrdy_q;
    assign read_data[c]   = rdata_q;
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_data_mem_slave.sv
// Two DUTs (LATENCY 1 and 3) share one stimulus stream; a transaction-level model
// predicts completion cycles and read data, and a monitor matches every ready pulse.
module tb_data_mem_slave;
  localparam int NC = 4, AB = 8, DB = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic [NC-1:0]         read_valid, write_valid;
  logic [NC-1:0][AB-1:0] read_address, write_address;
  logic [NC-1:0][DB-1:0] write_data;
  logic                  load_en;
  logic [AB-1:0]         load_address;
  logic [DB-1:0]         load_data;
  logic [NC-1:0]         rr1, wr1, rr3, wr3;
  logic [NC-1:0][DB-1:0] rd1, rd3;
  logic                  busy1, busy3;

  data_mem_slave #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address), .read_ready(rr1), .read_data(rd1),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .write_ready(wr1), .load_en(load_en), .load_address(load_address), .load_data(load_data),
    .busy(busy1));

  data_mem_slave #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address), .read_ready(rr3), .read_data(rd3),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .write_ready(wr3), .load_en(load_en), .load_address(load_address), .load_data(load_data),
    .busy(busy3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int d; int ch; int kind; int cyc; logic [DB-1:0] data; } exp_t;
  exp_t          sb[$];
  logic [DB-1:0] mdl [256];
  logic [DB-1:0] last_rd [2][NC];
  int            op [NC];
  logic [AB-1:0] ad [NC];
  logic [DB-1:0] dt [NC];
  int            checks = 0, errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: every ready pulse must match a predicted completion.
  always @(negedge clk) begin : mon
    logic          rdy;
    logic [DB-1:0] dat;
    int            idx;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 2; k++) begin
          rdy = (d == 0) ? ((k == 0) ? rr1[c] : wr1[c]) : ((k == 0) ? rr3[c] : wr3[c]);
          dat = (d == 0) ? rd1[c] : rd3[c];
          if (rdy) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].d == d && sb[i].ch == c && sb[i].kind == k) idx = i;
            if (idx < 0) chk($sformatf("unexpected_ready lat%0d ch%0d kind%0d", d*2+1, c, k), 1, 0);
            else begin
              chk($sformatf("ready_cycle lat%0d ch%0d kind%0d", d*2+1, c, k), cyc, sb[idx].cyc);
              if (k == 0) chk($sformatf("read_data lat%0d ch%0d", d*2+1, c), dat, sb[idx].data);
              sb.delete(idx);
            end
          end
        end
  end

  task automatic clear_ops();
    for (int c = 0; c < NC; c++) begin op[c] = 0; ad[c] = '0; dt[c] = '0; end
  endtask

  task automatic preload(input int a, input int v);
    @(negedge clk);
    load_en = 1'b1; load_address = 8'(a); load_data = 8'(v);
    mdl[a] = 8'(v);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // All requests issued on one edge, valids held 14 cycles; loads occupy edges A+lo..A+lo+n-1.
  task automatic run_batch(input int lo, input int n);
    int a, slot, lat;
    bit any;
    @(negedge clk);
    a = cyc + 1;
    any = 1'b0;
    for (int c = 0; c < NC; c++) begin
      read_valid[c]    = (op[c] == 1);
      write_valid[c]   = (op[c] == 2);
      read_address[c]  = ad[c];
      write_address[c] = ad[c];
      write_data[c]    = dt[c];
      if (op[c] != 0) any = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      for (int c = 0; c < NC; c++)
        if (op[c] == 1) begin
          sb.push_back('{d, c, 0, a + lat, mdl[ad[c]]});
          last_rd[d][c] = mdl[ad[c]];
        end
      slot = a + lat;
      for (int c = 0; c < NC; c++)
        if (op[c] == 2) begin
          while (n > 0 && slot >= a + lo && slot < a + lo + n) slot++;
          sb.push_back('{d, c, 1, slot, 8'd0});
          slot++;
        end
    end
    for (int c = 0; c < NC; c++) if (op[c] == 2) mdl[ad[c]] = dt[c];
    for (int t = 0; t < 14; t++) begin
      if (n > 0 && t >= lo && t < lo + n) begin
        load_en = 1'b1; load_address = 8'(192 + t); load_data = 8'($urandom);
        mdl[192 + t] = load_data;
      end else load_en = 1'b0;
      if (t == 1 && any) begin
        chk("busy_during lat1", busy1, 1);
        chk("busy_during lat3", busy3, 1);
      end
      @(negedge clk);
    end
    read_valid = '0; write_valid = '0; load_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy1 && !busy3) break;
    end
    chk("busy_idle", int'(busy1 | busy3), 0);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("data_hold lat1 ch%0d", c), rd1[c], last_rd[0][c]);
      chk($sformatf("data_hold lat3 ch%0d", c), rd3[c], last_rd[1][c]);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " lat1"}, int'({rr1, wr1, busy1} != '0) + int'(rd1 != '0), 0);
    chk({nm, " lat3"}, int'({rr3, wr3, busy3} != '0) + int'(rd3 != '0), 0);
  endtask

  initial begin
    read_valid = '0; write_valid = '0; read_address = '0; write_address = '0;
    write_data = '0; load_en = 1'b0; load_address = '0; load_data = '0;
    for (int d = 0; d < 2; d++) for (int c = 0; c < NC; c++) last_rd[d][c] = '0;
    #1 check_zero("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) preload(i, (i < 8) ? (i % 4) + 1 : int'($urandom_range(0, 255)));

    clear_ops(); op[0] = 1; ad[0] = 8'd2; run_batch(0, 0);
    clear_ops(); op[1] = 1; ad[1] = 8'd5; run_batch(0, 0);
    clear_ops();
    for (int c = 0; c < NC; c++) begin op[c] = 2; ad[c] = 8'(8 + c); end
    dt[0] = 8'd7; dt[1] = 8'd10; dt[2] = 8'd15; dt[3] = 8'd22;
    run_batch(0, 0);
    clear_ops();
    for (int c = 0; c < NC; c++) begin op[c] = 1; ad[c] = 8'(8 + c); end
    run_batch(0, 0);
    clear_ops(); op[0] = 2; ad[0] = 8'd4; dt[0] = 8'd9; op[1] = 1; ad[1] = 8'd4; run_batch(0, 0);
    clear_ops(); op[2] = 1; ad[2] = 8'd4; run_batch(0, 0);

    // Reset while ch3 waits on a write to addr 20: write must not land.
    @(negedge clk);
    write_valid[3] = 1'b1; write_address[3] = 8'd20; write_data[3] = 8'hAA;
    @(negedge clk);
    chk("busy_before_abort lat1", busy1, 1);
    chk("busy_before_abort lat3", busy3, 1);
    reset = 1'b0;
    #1 check_zero("async_reset");
    write_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) for (int c = 0; c < NC; c++) last_rd[d][c] = '0;
    clear_ops(); op[0] = 1; ad[0] = 8'd20; run_batch(0, 0);

    // Backdoor loads stall the write port.
    clear_ops();
    for (int c = 0; c < NC; c++) begin op[c] = 2; ad[c] = 8'(12 + c); dt[c] = 8'($urandom); end
    run_batch(1, 4);

    for (int b = 0; b < 25; b++) begin
      for (int c = 0; c < NC; c++) begin
        op[c] = $urandom_range(0, 2);
        ad[c] = 8'($urandom_range(0, 31));
        dt[c] = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) run_batch($urandom_range(0, 4), $urandom_range(1, 3));
      else run_batch(0, 0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
